mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 23 ++
 rtl/mul_div_unit.sv | 90 +++++++++
 tb/tb_mul_div_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and latency constants for the HI/LO multiply/divide unit.
// Imported by the unit, the decoder and the hazard unit.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: result computed at launch, committed after a
// fixed countdown so the pipeline sees a multi-cycle operation.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rdHi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdOut
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] a_ext, b_ext;
    logic        sgn;
    md_op_e      op_e;

    assign busy  = (cnt_q != 4'd0);
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign mdOut = rdHi ? hi_q : lo_q;

    always_comb begin
        op_e  = md_op_e'(op);
        sgn   = md_is_signed(op_e);
        a_ext = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext = sgn ? {{32{b[31]}}, b} : {32'd0, b};

        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        cnt_d     = busy ? cnt_q - 4'd1 : cnt_q;

        if (cnt_q == 4'd1) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end

        if (start && !busy) begin
            case (op_e)
                MD_MULT, MD_MULTU: begin
                    {pend_hi_d, pend_lo_d} = a_ext * b_ext;
                    cnt_d = MULT_CYCLES;
                end
                MD_DIV, MD_DIVU: begin
                    // Divide by zero commits the current HI/LO back unchanged
                    if (b == 32'd0) begin
                        pend_hi_d = hi_q;
                        pend_lo_d = lo_q;
                    end else begin
                        pend_hi_d = 32'($signed(a_ext) % $signed(b_ext));
                        pend_lo_d = 32'($signed(a_ext) / $signed(b_ext));
                    end
                    cnt_d = DIV_CYCLES;
                end
                MD_MTHI: hi_d = a;
                MD_MTLO: lo_d = a;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            cnt_q     <= 4'd0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO pushed at launch,
// popped and compared when busy falls.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rdHi;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdOut;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mul_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .rdHi  (rdHi),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .mdOut (mdOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(logic [2:0] o, logic [31:0] x,
                                   logic [31:0] y, logic [31:0] h,
                                   logic [31:0] l);
        exp_t r;
        longint p;
        int q;
        int m;
        r = '{hi: h, lo: l};
        case (o)
            3'd1: begin
                p = longint'($signed(x)) * longint'($signed(y));
                r = exp_t'(p);
            end
            3'd2: r = exp_t'({32'd0, x} * {32'd0, y});
            3'd3: begin
                if (y == 32'd0) r = '{hi: h, lo: l};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    r = '{hi: 32'd0, lo: 32'h8000_0000};
                else begin
                    q = $signed(x) / $signed(y);
                    m = $signed(x) % $signed(y);
                    r = '{hi: m, lo: q};
                end
            end
            3'd4: begin
                if (y != 32'd0) r = '{hi: x % y, lo: x / y};
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic launch(logic [2:0] o, logic [31:0] x, logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        op    = 3'd0;
    endtask

    task automatic move(logic [2:0] o, logic [31:0] x, string nm);
        launch(o, x, 32'd0);
        if (o == 3'd5) m_hi = x;
        else m_lo = x;
        checks++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL %s: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                     nm, busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic wait_done(int lat, int poke_at, string nm);
        int   n;
        logic held;
        exp_t e;
        n    = 0;
        held = 1'b1;
        while (busy === 1'b1 && n < 30) begin
            if (hi !== m_hi || lo !== m_lo) held = 1'b0;
            a = $urandom;
            b = $urandom;
            if (n == poke_at - 1) begin
                start = 1'b1;
                op    = 3'd6;
                a     = 32'h55;
            end else begin
                start = 1'b0;
                op    = 3'd0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles want %0d", nm, n, lat);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL %s_hold: hi/lo changed while busy, want %h/%h",
                     nm, m_hi, m_lo);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: queue empty", nm);
        end else begin
            e = sb.pop_front();
            if (hi !== e.hi || lo !== e.lo) begin
                errors++;
                $display("FAIL %s_result: hi=%h lo=%h want hi=%h lo=%h",
                         nm, hi, lo, e.hi, e.lo);
            end
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic run_op(logic [2:0] o, logic [31:0] x, logic [31:0] y,
                          logic [31:0] eh, logic [31:0] el, int lat,
                          string nm);
        launch(o, x, y);
        sb.push_back('{hi: eh, lo: el});
        wait_done(lat, -1, nm);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || mdOut !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%b hi=%h lo=%h mdOut=%h want all 0",
                     busy, hi, lo, mdOut);
        end
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        tick();
    endtask

    task automatic test_mult_timing();
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
               5, "mult");
    endtask

    task automatic test_multu_div();
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 5, "multu");
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               10, "div_neg");
    endtask

    task automatic test_div_edge();
        move(3'd5, 32'h11, "mthi");
        move(3'd6, 32'h22, "mtlo");
        run_op(3'd4, 32'd7, 32'd0, 32'h11, 32'h22, 10, "divu_zero");
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
               10, "div_ovf");
    endtask

    task automatic test_start_while_busy();
        launch(3'd3, 32'd100, 32'd7);
        sb.push_back('{hi: 32'd2, lo: 32'd14});
        wait_done(10, 3, "busy_start");
        checks++;
        if (lo === 32'h55) begin
            errors++;
            $display("FAIL busy_start_mtlo: lo=%h want not 00000055", lo);
        end
    endtask

    task automatic test_reset_mid();
        logic clean;
        move(3'd5, 32'h99, "mthi_pre");
        launch(3'd1, 32'd3, 32'd4);
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0/0/0",
                     busy, hi, lo);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        tick();
        reset = 1'b0;
        clean = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) clean = 1'b0;
        end
        checks++;
        if (!clean) begin
            errors++;
            $display("FAIL reset_abort: hi=%h lo=%h want no commit", hi, lo);
        end
        run_op(3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5, "post_reset");
    endtask

    task automatic test_read_mux();
        move(3'd5, 32'hA, "mthi_a");
        move(3'd6, 32'hB, "mtlo_b");
        rdHi = 1'b1;
        #1;
        checks++;
        if (mdOut !== 32'hA) begin
            errors++;
            $display("FAIL mux_hi: mdOut=%h want 0000000a", mdOut);
        end
        rdHi = 1'b0;
        #1;
        checks++;
        if (mdOut !== 32'hB) begin
            errors++;
            $display("FAIL mux_lo: mdOut=%h want 0000000b", mdOut);
        end
    endtask

    task automatic test_noop();
        logic [2:0] ops [2];
        ops[0] = 3'd0;
        ops[1] = 3'd7;
        foreach (ops[i]) begin
            launch(ops[i], 32'h1234, 32'h5678);
            checks++;
            if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
                errors++;
                $display("FAIL noop_%0d: busy=%b hi=%h lo=%h want 0 %h %h",
                         ops[i], busy, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        exp_t        e;
        for (int i = 0; i < 10; i++) begin
            o = 3'($urandom_range(1, 4));
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (i == 0) y = 32'hFFFF_FFF0;
            e = model(o, x, y, m_hi, m_lo);
            launch(o, x, y);
            sb.push_back(e);
            wait_done((o <= 3'd2) ? 5 : 10, -1, "b2b");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        start  = 1'b0;
        op     = 3'd0;
        a      = 32'd0;
        b      = 32'd0;
        rdHi   = 1'b0;
        reset  = 1'b1;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        test_reset();
        test_mult_timing();
        test_multu_div();
        test_div_edge();
        test_start_while_busy();
        test_reset_mid();
        test_read_mux();
        test_noop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
